prog_clk_div: RTL and testbench

//  Runtime-programmable clock-enable/divided-clock generator; replaces fixed /2,/4,/64 dividers.

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/prog_clk_div.sv | 126 ++++++++++++
 tb/tb_prog_clk_div.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Holds the FSM state encoding, the minimum legal divisor and the clamp helper.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } clk_div_state_t;

  localparam int DIV_MIN = 2;

  // Operates on a 32-bit value so it serves any counter width up to 32 bits.
  function automatic logic [31:0] div_clamp(input logic [31:0] div);
    return (div < 32'(DIV_MIN)) ? 32'(DIV_MIN) : div;
  endfunction

endpackage

// File: rtl/prog_clk_div.sv
// Runtime-programmable divided clock / clock-enable generator with glitch-free divisor updates.
// Define CLKDIV_TICK_EN to add the o_tick port (one pulse in the last cycle of each period).
module prog_clk_div
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_div_vld,
  output logic             o_div_rdy,
  output logic             o_gen_clk,
  output logic             o_busy
`ifdef CLKDIV_TICK_EN
  ,
  output logic             o_tick
`endif
);

  clk_div_state_t   state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] div_reg, div_next;
  logic [CNT_W-1:0] pend_reg, pend_next;
  logic             pend_vld_reg, pend_vld_next;
  logic             gen_clk_reg, gen_clk_next;
`ifdef CLKDIV_TICK_EN
  logic             tick_reg, tick_next;
`endif

  logic             boundary;
  logic             accept;
  logic [CNT_W-1:0] div_clamped;
  logic [CNT_W-1:0] low_next;

  assign div_clamped = CNT_W'(div_clamp(32'(i_div)));
  assign accept      = i_div_vld && !pend_vld_reg;
  assign boundary    = (state_reg != ST_IDLE) && (cnt_reg == div_reg - CNT_W'(1));

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    div_next      = div_reg;
    pend_next     = pend_reg;
    pend_vld_next = pend_vld_reg;

    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (i_en) state_next = ST_RUN;
      end
      ST_RUN: begin
        cnt_next = boundary ? '0 : cnt_reg + CNT_W'(1);
        // Disable seen in the last cycle of a period ends the run right here.
        if (!i_en) state_next = boundary ? ST_IDLE : ST_STOP;
      end
      ST_STOP: begin
        cnt_next = boundary ? '0 : cnt_reg + CNT_W'(1);
        if (i_en) state_next = ST_RUN;
        else if (boundary) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase

    if (state_next == ST_IDLE) cnt_next = '0;

    // Apply and accept are mutually exclusive because accept needs pend_vld_reg low.
    if (boundary && pend_vld_reg) begin
      div_next      = pend_reg;
      pend_vld_next = 1'b0;
    end

    if (accept) begin
      if (state_reg == ST_IDLE) begin
        div_next = div_clamped;
      end else begin
        pend_next     = div_clamped;
        pend_vld_next = 1'b1;
      end
    end

    // Output flop is fed from next-cycle count and divisor so it stays aligned with cnt.
    low_next     = div_next - (div_next >> 1);
    gen_clk_next = (state_next != ST_IDLE) && (cnt_next >= low_next);
`ifdef CLKDIV_TICK_EN
    tick_next    = (state_next != ST_IDLE) && (cnt_next == div_next - CNT_W'(1));
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      div_reg      <= CNT_W'(DEF_DIV);
      pend_reg     <= '0;
      pend_vld_reg <= 1'b0;
      gen_clk_reg  <= 1'b0;
`ifdef CLKDIV_TICK_EN
      tick_reg     <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      div_reg      <= div_next;
      pend_reg     <= pend_next;
      pend_vld_reg <= pend_vld_next;
      gen_clk_reg  <= gen_clk_next;
`ifdef CLKDIV_TICK_EN
      tick_reg     <= tick_next;
`endif
    end
  end

  assign o_div_rdy = !pend_vld_reg;
  assign o_gen_clk = gen_clk_reg;
  assign o_busy    = (state_reg != ST_IDLE);
`ifdef CLKDIV_TICK_EN
  assign o_tick    = tick_reg;
`endif

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed bench for prog_clk_div (CNT_W=8 so the maximum divisor is cheap to exercise).
// Builds with or without CLKDIV_TICK_EN; the tick checks follow the define.
module tb_prog_clk_div;

  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 4;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [CNT_W-1:0] div;
  logic             div_vld;
  logic             div_rdy;
  logic             gen_clk;
  logic             busy;
`ifdef CLKDIV_TICK_EN
  logic             tick_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  prog_clk_div #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_en      (en),
    .i_div     (div),
    .i_div_vld (div_vld),
    .o_div_rdy (div_rdy),
    .o_gen_clk (gen_clk),
    .o_busy    (busy)
`ifdef CLKDIV_TICK_EN
    ,
    .o_tick    (tick_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected waveform from the period formula: high when phase >= N - N/2.
  task automatic expect_wave(input string tag, input int n_cyc, input int n_div, input int phase);
    int p;
    for (int i = 0; i < n_cyc; i++) begin
      step();
      p = (phase + i) % n_div;
      chk(tag, 32'(gen_clk), 32'(p >= (n_div - n_div / 2)));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
`ifdef CLKDIV_TICK_EN
      chk({tag, "_tick"}, 32'(tick_o), 32'(p == n_div - 1));
`endif
    end
    $display("wave %s: %0d cycles N=%0d from phase %0d", tag, n_cyc, n_div, phase);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gen"}, 32'(gen_clk), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef CLKDIV_TICK_EN
    chk({tag, "_tick"}, 32'(tick_o), 32'd0);
`endif
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    div     = '0;
    div_vld = 1'b0;
    step();
    step();
    chk_idle("reset");
    chk("reset_rdy", 32'(div_rdy), 32'd1);
    $display("reset: outputs checked");

    // Default divisor 4 straight out of reset.
    rst_n = 1'b1;
    en    = 1'b1;
    expect_wave("div4", 13, 4, 0);
    en = 1'b0;
    expect_wave("div4_stop", 3, 4, 1);
    step();
    chk_idle("div4_idle");

    // Load 64 in IDLE, then run.
    chk("idle_rdy", 32'(div_rdy), 32'd1);
    div = 8'd64; div_vld = 1'b1;
    step();
    div_vld = 1'b0;
    chk("idle_load_rdy", 32'(div_rdy), 32'd1);
    chk_idle("idle_load");
    en = 1'b1;
    expect_wave("div64", 70, 64, 0);

    // Load 5 mid-period; a second request while pending must be ignored.
    div = 8'd5; div_vld = 1'b1;
    step();
    chk("pend_rdy", 32'(div_rdy), 32'd0);
    chk("pend_gen", 32'(gen_clk), 32'd0);
    div = 8'd9;
    expect_wave("div64_tail", 1, 64, 7);
    div_vld = 1'b0;
    expect_wave("div64_tail", 56, 64, 8);
    chk("pend_rdy_end", 32'(div_rdy), 32'd0);
    expect_wave("div5", 10, 5, 0);
    chk("div5_rdy", 32'(div_rdy), 32'd1);

    // Accept on a boundary cycle: old N runs one more period. 0 clamps to 2.
    div = 8'd0; div_vld = 1'b1;
    expect_wave("div5_hold", 1, 5, 0);
    div_vld = 1'b0;
    chk("div0_rdy", 32'(div_rdy), 32'd0);
    expect_wave("div5_hold", 4, 5, 1);
    expect_wave("div0_as2", 6, 2, 0);
    chk("div0_rdy_end", 32'(div_rdy), 32'd1);

    div = 8'd1; div_vld = 1'b1;
    expect_wave("div1_as2", 1, 2, 0);
    div_vld = 1'b0;
    expect_wave("div1_as2", 5, 2, 1);

    // Maximum divisor 2^CNT_W-1.
    div = 8'd255; div_vld = 1'b1;
    expect_wave("div2_pre255", 1, 2, 0);
    div_vld = 1'b0;
    expect_wave("div2_pre255", 1, 2, 1);
    expect_wave("div255", 258, 255, 0);

    // Switch to 8 and drop enable in the high phase.
    div = 8'd8; div_vld = 1'b1;
    expect_wave("div255_tail", 1, 255, 3);
    div_vld = 1'b0;
    expect_wave("div255_tail", 251, 255, 4);
    expect_wave("div8", 6, 8, 0);
    en = 1'b0;
    expect_wave("div8_stop", 2, 8, 6);
    step();
    chk_idle("div8_idle");

    // Drop and re-raise within one period: no break in the waveform.
    en = 1'b1;
    expect_wave("div8_run", 3, 8, 0);
    en = 1'b0;
    expect_wave("div8_drop", 2, 8, 3);
    en = 1'b1;
    expect_wave("div8_unbroken", 13, 8, 5);

    // Reset mid-period with a pending divisor.
    div = 8'd20; div_vld = 1'b1;
    step();
    div_vld = 1'b0;
    chk("rst_pend_rdy", 32'(div_rdy), 32'd0);
    rst_n = 1'b0;
    step();
    chk_idle("mid_rst");
    chk("mid_rst_rdy", 32'(div_rdy), 32'd1);
    rst_n = 1'b1;
    expect_wave("after_rst_div4", 8, 4, 0);

    // N=3: tick on every third cycle, including the final STOP period.
    div = 8'd3; div_vld = 1'b1;
    expect_wave("div4_pre3", 1, 4, 0);
    div_vld = 1'b0;
    expect_wave("div4_pre3", 3, 4, 1);
    expect_wave("div3", 10, 3, 0);
    en = 1'b0;
    expect_wave("div3_stop", 2, 3, 1);
    step();
    chk_idle("div3_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Guard against a stalled simulation.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
